riscv_alu_muldiv: RTL and testbench

Parametrised multi-cycle integer multiply/divide unit for the RISC-V M extension. It sits beside the single-cycle integer ALU in the execute stage. The pipeline hands it one operation at a time through a valid/ready request port and receives the result through a valid/ready response port. Multiplication uses a configurable radix; division is restoring, one bit per cycle. Division by zero and signed overflow are handled by a single-cycle fast path.

---
 rtl/riscv_muldiv_pkg.sv | 54 +++++
 rtl/riscv_muldiv_div_step.sv | 30 +++
 rtl/riscv_alu_muldiv.sv | 197 +++++++++++++++++++
 tb/tb_riscv_alu_muldiv.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_muldiv_pkg.sv
// riscv_muldiv_pkg
// Shared types and per-op decode for the RISC-V M-extension multiply/divide
// unit (riscv_alu_muldiv) and its restoring divide step.
//   t_muldiv_op    : req_op encodings (0 MUL .. 7 REMU)
//   t_muldiv_state : IDLE / MUL / DIV / DONE
//   is_signed_rs1, is_signed_rs2, result_high, result_rem : per-op decode
//   is_div_op      : op belongs to the divide group (ops 4-7)
package riscv_muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } t_muldiv_op;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } t_muldiv_state;

   // One bit per op, indexed by the op encoding.
   localparam logic [7:0] SIGNED_RS1_MASK  = 8'b0101_0111; // MUL MULH MULHSU DIV REM
   localparam logic [7:0] SIGNED_RS2_MASK  = 8'b0101_0011; // MUL MULH DIV REM
   localparam logic [7:0] RESULT_HIGH_MASK = 8'b0000_1110; // MULH MULHSU MULHU
   localparam logic [7:0] RESULT_REM_MASK  = 8'b1100_0000; // REM REMU

   function automatic logic is_signed_rs1(input t_muldiv_op op);
      return SIGNED_RS1_MASK[3'(op)];
   endfunction

   function automatic logic is_signed_rs2(input t_muldiv_op op);
      return SIGNED_RS2_MASK[3'(op)];
   endfunction

   function automatic logic result_high(input t_muldiv_op op);
      return RESULT_HIGH_MASK[3'(op)];
   endfunction

   function automatic logic result_rem(input t_muldiv_op op);
      return RESULT_REM_MASK[3'(op)];
   endfunction

   function automatic logic is_div_op(input t_muldiv_op op);
      return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   endfunction

endpackage

// File: rtl/riscv_muldiv_div_step.sv
// riscv_muldiv_div_step
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder, subtract the divisor when it fits.
//   rem          in  XLEN+1  current partial remainder
//   divisor      in  XLEN    divisor magnitude
//   dividend_bit in  1       next dividend bit (MSB first)
//   rem_next     out XLEN+1  partial remainder after this step
//   q_bit        out 1       quotient bit produced by this step
module riscv_muldiv_div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN:0]   rem,
   input  logic [XLEN-1:0] divisor,
   input  logic            dividend_bit,
   output logic [XLEN:0]   rem_next,
   output logic            q_bit
);

   logic [XLEN+1:0] shifted;
   logic [XLEN:0]   diff;

   always_comb begin
      shifted = {rem, dividend_bit};
      q_bit   = (shifted >= {2'b00, divisor});
      // Only taken when q_bit is set, so the XLEN+1-bit difference is exact.
      diff     = shifted[XLEN:0] - {1'b0, divisor};
      rem_next = q_bit ? diff : shifted[XLEN:0];
   end

endmodule

// File: rtl/riscv_alu_muldiv.sv
// riscv_alu_muldiv
// Multi-cycle RISC-V M-extension multiply/divide unit.
// Multiply: MUL_BITS_PER_CYCLE multiplier bits per cycle into a 2*XLEN
// accumulator. Divide: restoring, one bit per cycle. Divide-by-zero and
// signed overflow finish in one cycle without sign fix-up.
// Build option: define RISCV_ALU_MULDIV_DIV_EN to include the divider; without
// it ops 4-7 complete in one cycle with resp_illegal = 1 and result 0.
// Ports:
//   clk, reset_n (sync, active-low)
//   req_valid/req_ready, req_op[2:0], req_rs1, req_rs2 : request
//   cancel                                              : flush in-flight op
//   resp_valid/resp_ready, resp_result, resp_illegal    : response
//   busy                                                : state != IDLE
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; req_ready depends only on state, resp_* are held while
// resp_valid is high and resp_ready is low.
module riscv_alu_muldiv #(
   parameter int XLEN               = 32,
   parameter int MUL_BITS_PER_CYCLE = 2
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_op,
   input  logic [XLEN-1:0] req_rs1,
   input  logic [XLEN-1:0] req_rs2,
   input  logic            cancel,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_result,
   output logic            resp_illegal,
   output logic            busy
);
   import riscv_muldiv_pkg::*;

   localparam int MUL_STEPS = XLEN / MUL_BITS_PER_CYCLE;
   localparam int MUL_W     = XLEN + MUL_BITS_PER_CYCLE;
   localparam int CNT_W     = $clog2(XLEN + 1);
   localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_STEPS - 1);

   t_muldiv_state         state;
   t_muldiv_op            op_q;
   logic                  neg_q;      // product / quotient negate
   logic [XLEN-1:0]       mag1_q;     // multiplicand magnitude
   logic [2*XLEN-1:0]     acc_q;      // {partial product, remaining multiplier}
   logic [CNT_W-1:0]      cnt_q;
   logic [XLEN-1:0]       resp_result_q;
   logic                  resp_illegal_q;

   t_muldiv_op            req_op_e;
   logic                  s1, s2;
   logic [XLEN-1:0]       mag_rs1, mag_rs2;
   logic [MUL_W-1:0]      mul_sum;
   logic [2*XLEN-1:0]     acc_next, prod_fix;
   logic [XLEN-1:0]       mul_res;

   assign req_op_e = t_muldiv_op'(req_op);

   always_comb begin
      s1      = is_signed_rs1(req_op_e) & req_rs1[XLEN-1];
      s2      = is_signed_rs2(req_op_e) & req_rs2[XLEN-1];
      mag_rs1 = s1 ? -req_rs1 : req_rs1;
      mag_rs2 = s2 ? -req_rs2 : req_rs2;
      // Add multiplicand x next digit into the upper half, then shift right.
      mul_sum  = {{MUL_BITS_PER_CYCLE{1'b0}}, acc_q[2*XLEN-1:XLEN]}
               + ({{MUL_BITS_PER_CYCLE{1'b0}}, mag1_q}
                  * MUL_W'(acc_q[MUL_BITS_PER_CYCLE-1:0]));
      acc_next = {mul_sum, acc_q[XLEN-1:MUL_BITS_PER_CYCLE]};
      prod_fix = neg_q ? -acc_next : acc_next;
      mul_res  = result_high(op_q) ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
   end

`ifdef RISCV_ALU_MULDIV_DIV_EN
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN - 1);

   logic                  neg_rem_q;
   logic [XLEN-1:0]       divisor_q;
   logic [XLEN:0]         rem_q;
   logic [XLEN-1:0]       quo_q;      // dividend bits shift out, quotient bits in
   logic [XLEN:0]         rem_next;
   logic                  q_bit;
   logic [XLEN-1:0]       quo_next, div_res;
   logic                  div_zero, div_ovf;
   logic [XLEN-1:0]       fast_res;

   riscv_muldiv_div_step #(.XLEN(XLEN)) u_div_step (
      .rem          (rem_q),
      .divisor      (divisor_q),
      .dividend_bit (quo_q[XLEN-1]),
      .rem_next     (rem_next),
      .q_bit        (q_bit)
   );

   always_comb begin
      quo_next = {quo_q[XLEN-2:0], q_bit};
      if (result_rem(op_q))
         div_res = neg_rem_q ? -rem_next[XLEN-1:0] : rem_next[XLEN-1:0];
      else
         div_res = neg_q ? -quo_next : quo_next;
      div_zero = (req_rs2 == '0);
      div_ovf  = ((req_op_e == OP_DIV) || (req_op_e == OP_REM))
               && (req_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (req_rs2 == '1);
      // Fast-path results use the raw operands, never the sign fix-up.
      if (div_zero)
         fast_res = result_rem(req_op_e) ? req_rs1 : '1;
      else
         fast_res = result_rem(req_op_e) ? '0 : req_rs1;
   end
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state          <= ST_IDLE;
         op_q           <= OP_MUL;
         neg_q          <= 1'b0;
         mag1_q         <= '0;
         acc_q          <= '0;
         cnt_q          <= '0;
         resp_result_q  <= '0;
         resp_illegal_q <= 1'b0;
`ifdef RISCV_ALU_MULDIV_DIV_EN
         neg_rem_q      <= 1'b0;
         divisor_q      <= '0;
         rem_q          <= '0;
         quo_q          <= '0;
`endif
      end else if (cancel) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  op_q   <= req_op_e;
                  neg_q  <= s1 ^ s2;
                  mag1_q <= mag_rs1;
                  cnt_q  <= '0;
                  if (is_div_op(req_op_e)) begin
`ifdef RISCV_ALU_MULDIV_DIV_EN
                     neg_rem_q <= s1;
                     divisor_q <= mag_rs2;
                     quo_q     <= mag_rs1;
                     rem_q     <= '0;
                     if (div_zero || div_ovf) begin
                        resp_result_q  <= fast_res;
                        resp_illegal_q <= 1'b0;
                        state          <= ST_DONE;
                     end else begin
                        state <= ST_DIV;
                     end
`else
                     resp_result_q  <= '0;
                     resp_illegal_q <= 1'b1;
                     state          <= ST_DONE;
`endif
                  end else begin
                     acc_q <= {{XLEN{1'b0}}, mag_rs2};
                     state <= ST_MUL;
                  end
               end
            end
            ST_MUL: begin
               acc_q <= acc_next;
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == MUL_LAST) begin
                  resp_result_q  <= mul_res;
                  resp_illegal_q <= 1'b0;
                  state          <= ST_DONE;
               end
            end
`ifdef RISCV_ALU_MULDIV_DIV_EN
            ST_DIV: begin
               rem_q <= rem_next;
               quo_q <= quo_next;
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == DIV_LAST) begin
                  resp_result_q  <= div_res;
                  resp_illegal_q <= 1'b0;
                  state          <= ST_DONE;
               end
            end
`endif
            ST_DONE: begin
               if (resp_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready    = (state == ST_IDLE);
   assign busy         = (state != ST_IDLE);
   assign resp_valid   = (state == ST_DONE);
   assign resp_result  = resp_result_q;
   assign resp_illegal = resp_illegal_q;

endmodule

// File: tb/tb_riscv_alu_muldiv.sv
// tb_riscv_alu_muldiv
// Directed vectors for riscv_alu_muldiv (XLEN=32, 2 multiplier bits/cycle).
// A driver pushes the hand-computed response into a queue at acceptance; a
// monitor pops and compares result, illegal flag and latency on each response.
// With RISCV_ALU_MULDIV_DIV_EN undefined, ops 4-7 are expected to be illegal.
`timescale 1ns/1ps
module tb_riscv_alu_muldiv;
   localparam int XLEN    = 32;
   localparam int BPC     = 2;
   localparam int MUL_LAT = XLEN / BPC + 1;
   localparam int DIV_LAT = XLEN + 1;

   localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
   localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

   // ---------------- clock / reset ----------------
   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            req_valid = 1'b0;
   logic [2:0]      req_op = 3'd0;
   logic [XLEN-1:0] req_rs1 = '0;
   logic [XLEN-1:0] req_rs2 = '0;
   logic            cancel = 1'b0;
   logic            resp_ready = 1'b1;
   logic            req_ready, resp_valid, resp_illegal, busy;
   logic [XLEN-1:0] resp_result;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   riscv_alu_muldiv #(.XLEN(XLEN), .MUL_BITS_PER_CYCLE(BPC)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_rs1      (req_rs1),
      .req_rs2      (req_rs2),
      .cancel       (cancel),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_result  (resp_result),
      .resp_illegal (resp_illegal),
      .busy         (busy)
   );

   // ---------------- scoreboard ----------------
   logic [XLEN-1:0] exp_q[$];
   logic            exp_ill_q[$];
   int              exp_lat_q[$];
   int              acc_cyc_q[$];
   int              n_vec  = 0;
   int              n_fail = 0;

   task automatic check(input string name, input logic [XLEN-1:0] act,
                        input logic [XLEN-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h expected 0x%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor ----------------
   bit              seen = 1'b0;
   logic [XLEN-1:0] held;

   always @(negedge clk) begin
      if (reset_n && resp_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_resp", {31'd0, resp_valid}, '0);
         end else begin
            if (!seen) begin
               seen = 1'b1;
               held = resp_result;
               check("latency", XLEN'(cyc - acc_cyc_q[0] + 1), XLEN'(exp_lat_q[0]));
            end else begin
               check("hold_stable", resp_result, held);
            end
            if (resp_ready) begin
               check("result", resp_result, exp_q[0]);
               check("illegal", {31'd0, resp_illegal}, {31'd0, exp_ill_q[0]});
               void'(exp_q.pop_front());
               void'(exp_ill_q.pop_front());
               void'(exp_lat_q.pop_front());
               void'(acc_cyc_q.pop_front());
               seen = 1'b0;
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic wait_idle();
      int n = 0;
      while (!req_ready && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      if (!req_ready) check("req_ready_timeout", {31'd0, req_ready}, 32'd1);
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_q.size() != 0 || !req_ready) && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain", XLEN'(exp_q.size()), '0);
   endtask

   task automatic issue(input logic [2:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp_r,
                        input int lat, input bit expect_resp, input bit with_cancel);
      logic [XLEN-1:0] r = exp_r;
      logic            ill = 1'b0;
      int              l = lat;
`ifndef RISCV_ALU_MULDIV_DIV_EN
      if (op >= 3'd4) begin
         r   = '0;
         ill = 1'b1;
         l   = 1;
      end
`endif
      wait_idle();
      req_valid = 1'b1;
      req_op    = op;
      req_rs1   = a;
      req_rs2   = b;
      cancel    = with_cancel;
      @(posedge clk); #1;
      req_valid = 1'b0;
      cancel    = 1'b0;
      req_rs1   = $urandom_range(0, 255);
      req_rs2   = $urandom_range(0, 255);
      if (expect_resp && !with_cancel) begin
         exp_q.push_back(r);
         exp_ill_q.push_back(ill);
         exp_lat_q.push_back(l);
         acc_cyc_q.push_back(cyc);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_resp_valid"},   {31'd0, resp_valid},   '0);
      check({tag, "_resp_result"},  resp_result,           '0);
      check({tag, "_resp_illegal"}, {31'd0, resp_illegal}, '0);
      check({tag, "_busy"},         {31'd0, busy},         '0);
      check({tag, "_req_ready"},    {31'd0, req_ready},    32'd1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      logic [2:0] long_op;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Multiply
      issue(MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, MUL_LAT, 1, 0);
      issue(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT, 1, 0);
      issue(MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, MUL_LAT, 1, 0);
      issue(MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, 1, 0);
      issue(MUL,    32'd3,        32'd4,        32'd12,       MUL_LAT, 1, 0);
      issue(MULH,   32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT, 1, 0);
      issue(MUL,    32'h12345678, 32'h00000010, 32'h23456780, MUL_LAT, 1, 0);
      issue(MULHU,  32'h12345678, 32'h00000010, 32'h00000001, MUL_LAT, 1, 0);
      issue(MUL,    32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, MUL_LAT, 1, 0);
      issue(MULH,   32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, MUL_LAT, 1, 0);

      // Divide (illegal, latency 1 when the divider is not built)
      issue(DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT, 1, 0);
      issue(REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT, 1, 0);
      issue(DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT, 1, 0);
      issue(REM,    32'd7,        32'hFFFFFFFE, 32'h00000001, DIV_LAT, 1, 0);
      issue(DIVU,   32'd100,      32'd7,        32'd14,       DIV_LAT, 1, 0);
      issue(REMU,   32'd100,      32'd7,        32'd2,        DIV_LAT, 1, 0);
      issue(DIVU,   32'h80000000, 32'd3,        32'h2AAAAAAA, DIV_LAT, 1, 0);
      issue(REMU,   32'h80000000, 32'd3,        32'd2,        DIV_LAT, 1, 0);
      issue(DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, DIV_LAT, 1, 0);
      issue(DIVU,   32'd9,        32'd3,        32'd3,        DIV_LAT, 1, 0);
      // Fast paths
      issue(DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1, 1, 0);
      issue(REM,    32'd5,        32'd0,        32'd5,        1, 1, 0);
      issue(REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1, 1, 0);
      issue(DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1, 1, 0);
      issue(DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1, 0);
      issue(REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 1, 0);
      wait_drain();

      // Back-pressure: response held 10 cycles, no new request accepted
      resp_ready = 1'b0;
      issue(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT, 1, 0);
      n = 0;
      while (!resp_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("bp_req_ready", {31'd0, req_ready}, '0);
      end
      resp_ready = 1'b1;
      wait_drain();

      // Cancel at cycle 5 of a long operation
`ifdef RISCV_ALU_MULDIV_DIV_EN
      long_op = DIV;
`else
      long_op = MUL;
`endif
      issue(long_op, 32'd1000, 32'd3, '0, 0, 0, 0);
      repeat (4) @(posedge clk);
      #1;
      check("cancel_busy_before", {31'd0, busy}, 32'd1);
      cancel = 1'b1;
      @(posedge clk); #1;
      cancel = 1'b0;
      check("cancel_busy", {31'd0, busy}, '0);
      check("cancel_req_ready", {31'd0, req_ready}, 32'd1);
      check("cancel_resp_valid", {31'd0, resp_valid}, '0);
      repeat (40) @(posedge clk);
      #1;
      check("cancel_no_resp", {31'd0, resp_valid}, '0);

      // Cancel in the cycle of acceptance
      issue(DIV, 32'd5, 32'd0, '0, 0, 0, 1);
      check("cancel_accept_busy", {31'd0, busy}, '0);
      repeat (5) @(posedge clk);
      #1;
      check("cancel_accept_no_resp", {31'd0, resp_valid}, '0);

      // Reset mid-multiply (previous result non-zero)
      issue(MUL, 32'd3, 32'd4, 32'd12, MUL_LAT, 1, 0);
      wait_drain();
      issue(MUL, 32'd7, 32'd9, '0, 0, 0, 0);
      repeat (5) @(posedge clk);
      #1;
      reset_n = 1'b0;
      @(posedge clk); #1;
      check_reset_outputs("midreset");
      reset_n = 1'b1;
      issue(MUL, 32'd6, 32'd7, 32'd42, MUL_LAT, 1, 0);
      issue(DIVU, 32'd9, 32'd3, 32'd3, DIV_LAT, 1, 0);
      wait_drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
